// File: rtl/tiny_dnn_seq.sv
// Command sequencer for the tiny_dnn_core MAC: runs ds passes of (init, ss x exec, bias),
// drives weight/data addresses and pipeline-aligned ping-pong buffer selects.
module tiny_dnn_seq #(
    parameter int f_size = 1024,
    parameter int aw     = 10,
    parameter int dw     = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [aw-1:0] ss,
    input  logic [aw-1:0] ds,
    output logic          busy,
    output logic          done,
    output logic          init,
    output logic          exec,
    output logic          bias,
    output logic [aw-1:0] ra,
    output logic          sum_ip,
    output logic          sum_op,
    output logic          d_en,
    output logic [dw-1:0] d_addr,
    output logic          out_valid,
    output logic [aw-1:0] out_idx
);

    typedef enum logic [2:0] {IDLE, INIT, EXEC, BIAS, DRAIN} state_t;

    state_t        state_reg, state_next;
    logic [aw-1:0] ss_reg, ds_reg, k_reg, p_reg;
    logic [dw-1:0] dcnt_reg, d_addr_reg;
    logic          d_en_reg;
    logic          b_reg, b_d1_reg, sum_ip_reg;
    logic          v1_reg, v2_reg, last1_reg, last2_reg, buf1_reg, buf2_reg;
    logic [aw-1:0] idx1_reg, idx2_reg, out_idx_reg;
    logic          out_valid_reg, sum_op_reg, done_reg;

    logic          init_c, exec_c, bias_c, accept_c, degen_c;
    logic [aw-1:0] ra_c;

    always_comb begin
        state_next = state_reg;
        init_c     = 1'b0;
        exec_c     = 1'b0;
        bias_c     = 1'b0;
        accept_c   = 1'b0;
        degen_c    = 1'b0;
        ra_c       = '0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (ss != '0 && ds != '0) begin
                        accept_c   = 1'b1;
                        state_next = INIT;
                    end else begin
                        degen_c = 1'b1;
                    end
                end
            end
            INIT: begin
                init_c     = 1'b1;
                state_next = EXEC;
            end
            EXEC: begin
                exec_c = 1'b1;
                ra_c   = k_reg;
                if (k_reg == ss_reg - 1'b1)
                    state_next = BIAS;
            end
            BIAS: begin
                bias_c = 1'b1;
                ra_c   = aw'(f_size - 1);
                state_next = (p_reg == ds_reg - 1'b1) ? DRAIN : INIT;
            end
            DRAIN: begin
                // done_reg coincides with the final out_valid of the run
                if (done_reg)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            ss_reg        <= '0;
            ds_reg        <= '0;
            k_reg         <= '0;
            p_reg         <= '0;
            dcnt_reg      <= '0;
            d_addr_reg    <= '0;
            d_en_reg      <= 1'b0;
            b_reg         <= 1'b0;
            b_d1_reg      <= 1'b0;
            sum_ip_reg    <= 1'b0;
            v1_reg        <= 1'b0;
            v2_reg        <= 1'b0;
            last1_reg     <= 1'b0;
            last2_reg     <= 1'b0;
            buf1_reg      <= 1'b0;
            buf2_reg      <= 1'b0;
            idx1_reg      <= '0;
            idx2_reg      <= '0;
            out_idx_reg   <= '0;
            out_valid_reg <= 1'b0;
            sum_op_reg    <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept_c) begin
                ss_reg   <= ss;
                ds_reg   <= ds;
                k_reg    <= '0;
                p_reg    <= '0;
                dcnt_reg <= '0;
                b_reg    <= 1'b0;
            end
            if (init_c)
                k_reg <= '0;
            if (exec_c) begin
                k_reg    <= k_reg + 1'b1;
                dcnt_reg <= dcnt_reg + 1'b1;
            end
            if (bias_c) begin
                p_reg <= p_reg + 1'b1;
                b_reg <= ~b_reg;
            end

            d_en_reg <= exec_c;
            if (exec_c)
                d_addr_reg <= dcnt_reg;

            // Two-stage delay of b matches the core's init2/exec2/bias2 stage
            b_d1_reg   <= b_reg;
            sum_ip_reg <= b_d1_reg;

            // Completion pipeline: bias at T -> finished sum at T+3
            v1_reg    <= bias_c;
            idx1_reg  <= p_reg;
            buf1_reg  <= b_reg;
            last1_reg <= (p_reg == ds_reg - 1'b1);
            v2_reg    <= v1_reg;
            idx2_reg  <= idx1_reg;
            buf2_reg  <= buf1_reg;
            last2_reg <= last1_reg;

            out_valid_reg <= v2_reg;
            if (v2_reg) begin
                out_idx_reg <= idx2_reg;
                sum_op_reg  <= buf2_reg;
            end
            done_reg <= (v2_reg && last2_reg) || degen_c;
        end
    end

    assign busy      = (state_reg != IDLE);
    assign done      = done_reg;
    assign init      = init_c;
    assign exec      = exec_c;
    assign bias      = bias_c;
    assign ra        = ra_c;
    assign sum_ip    = sum_ip_reg;
    assign sum_op    = sum_op_reg;
    assign d_en      = d_en_reg;
    assign d_addr    = d_addr_reg;
    assign out_valid = out_valid_reg;
    assign out_idx   = out_idx_reg;

endmodule
